// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants for the pipeline hazard controller and the register-match helper.
// State encodings stay plain localparams so older netlists can keep comparing against them.
package pipeline_hazard_controller_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    // Register $0 is hard-wired to zero, so writing it can never create a hazard.
    localparam int REG_ZERO_IDX = 0;

    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_LOAD_STALL = 1'b1;

endpackage

// File: rtl/pipeline_hazard_controller_match.sv
// Purely combinational load-use register match between EX and ID stages.
// Shared with the forwarding unit, so it knows nothing about stall length.
module hazard_reg_match
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  match
);

    logic dest_valid;
    logic rs_hit;
    logic rt_hit;

    assign dest_valid = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO_IDX));
    assign rs_hit     = (ex_rt == id_rs);
    assign rt_hit     = id_uses_rt && (ex_rt == id_rt);
    assign match      = dest_valid && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls, branch/jump
// flushes and a whole-pipe freeze while data memory is busy, plus a stall-cycle counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W        = REG_ADDR_W_DEFAULT,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STAT_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  ex_branch_taken,
    input  logic                  ex_jump,
    input  logic                  dmem_busy,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  id_ex_hold,
    output logic                  ex_mem_hold,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [STAT_W-1:0]     stall_cycles
);

    localparam int CNT_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [STAT_W-1:0] stat_reg;
    logic [STAT_W-1:0] stat_next;

    logic reg_match;
    logic hz;
    logic stall_now;
    logic freeze_now;
    logic flush_now;

    hazard_reg_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_match (
        .ex_mem_read (id_ex_mem_read),
        .ex_rt       (id_ex_rt),
        .id_rs       (if_id_rs),
        .id_rt       (if_id_rt),
        .id_uses_rt  (if_id_uses_rt),
        .match       (reg_match)
    );

    assign hz = (LOAD_STALL_CYCLES > 0) && reg_match;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_now  = 1'b0;
        freeze_now = 1'b0;
        flush_now  = 1'b0;
        if (dmem_busy) begin
            freeze_now = 1'b1;
        end else if (ex_branch_taken || ex_jump) begin
            flush_now  = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (state_reg == ST_LOAD_STALL) begin
            // The ID/EX bubble now hides the load, so hz is not consulted here.
            stall_now = 1'b1;
            if (cnt_reg == CNT_ONE) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg - CNT_ONE;
            end
        end else if (hz) begin
            stall_now = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_next = ST_LOAD_STALL;
                cnt_next   = CNT_LOAD;
            end
        end
    end

    always_comb begin
        stat_next = stat_reg;
        if (stall_now && (stat_reg != {STAT_W{1'b1}})) begin
            stat_next = stat_reg + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            stat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stat_reg  <= stat_next;
        end
    end

    // Outputs depend on live inputs, so reset must mask them as well.
    assign pc_hold      = !reset && (freeze_now || stall_now);
    assign if_id_hold   = !reset && (freeze_now || stall_now);
    assign id_ex_hold   = !reset && freeze_now;
    assign ex_mem_hold  = !reset && freeze_now;
    assign id_ex_bubble = !reset && (stall_now || flush_now);
    assign if_id_flush  = !reset && flush_now;
    assign stall_cycles = stat_reg;

endmodule
